if_fetch: RTL and testbench

//  IF stage. Owns the PC, issues instruction fetches on the sram-like inst port
//  and hands {adel, pc, inst} to ID. Consumes the WB redirect (exc_valid/exc_pc:

---
 rtl/cpu_defs_pkg.sv | 20 ++
 rtl/if_npc_sel.sv | 31 +++
 rtl/if_fetch.sv | 115 +++++++++++
 tb/tb_if_fetch.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: reset/exception vectors, IF->ID bus width and the
// IF fetch-state encoding.
package cpu_defs;

   localparam logic [31:0] RESET_PC       = 32'hBFC0_0000;
   localparam logic [31:0] EXC_ENTER_ADDR = 32'hBFC0_0380;
   localparam int          IF_ID_BUS_W    = 65;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } if_state_t;

   function automatic logic word_misaligned(input logic [31:0] addr);
      return addr[1] | addr[0];
   endfunction

endpackage

// File: rtl/if_npc_sel.sv
// Next-pc mux for IF: a WB redirect beats a branch taken at handoff, which
// beats the sequential pc+4. Holds the pc when nothing moves it.
module if_npc_sel (
   input  logic [31:0] pc,
   input  logic        exc_valid,
   input  logic [31:0] exc_pc,
   input  logic        handoff,
   input  logic        jbr_taken,
   input  logic [31:0] jbr_target,
   input  logic        br_pend,
   input  logic [31:0] br_tgt,
   output logic [31:0] npc
);

   always_comb begin
      npc = pc;
      if (exc_valid) begin
         npc = exc_pc;
      end else if (handoff) begin
         // A branch resolving in the very cycle the delay slot leaves IF
         // has not reached br_tgt yet, so take it straight from ID.
         if (jbr_taken)
            npc = jbr_target;
         else if (br_pend)
            npc = br_tgt;
         else
            npc = pc + 32'd4;
      end
   end

endmodule

// File: rtl/if_fetch.sv
// IF stage: owns the pc, fetches one word at a time over the sram-like inst
// port and presents {adel, pc, inst} to ID.
module if_fetch #(
   parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
   parameter int          BUS_W    = cpu_defs::IF_ID_BUS_W
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             exc_valid,
   input  logic [31:0]      exc_pc,
   input  logic             jbr_taken,
   input  logic [31:0]      jbr_target,
   input  logic             ID_allowin,
   output logic             inst_req,
   output logic [31:0]      inst_addr,
   input  logic             inst_addr_ok,
   input  logic [31:0]      inst_rdata,
   input  logic             inst_data_ok,
   output logic             IF_valid,
   output logic [BUS_W-1:0] IF_ID_bus,
   output logic [31:0]      IF_pc
);
   import cpu_defs::*;

   // Handshakes: a fetch is accepted on a cycle with inst_req & inst_addr_ok and
   // returns exactly one inst_data_ok later, in order; IF_ID_bus transfers to
   // ID on a cycle with IF_valid & ID_allowin and is held stable otherwise.

   if_state_t   state, state_nxt;
   logic [31:0] pc, pc_nxt, inst_r, br_tgt;
   logic        adel_r, br_pend;
   logic        misaligned, req_acc, handoff;

   assign misaligned = word_misaligned(pc);
   assign inst_req   = (state == S_REQ) & ~misaligned & resetn;
   assign inst_addr  = pc;
   assign req_acc    = inst_req & inst_addr_ok;
   assign handoff    = (state == S_HOLD) & ID_allowin;
   assign IF_valid   = (state == S_HOLD) & resetn;
   assign IF_ID_bus  = {adel_r, pc, inst_r};
   assign IF_pc      = pc;

   if_npc_sel u_npc_sel (
      .pc         (pc),
      .exc_valid  (exc_valid),
      .exc_pc     (exc_pc),
      .handoff    (handoff),
      .jbr_taken  (jbr_taken),
      .jbr_target (jbr_target),
      .br_pend    (br_pend),
      .br_tgt     (br_tgt),
      .npc        (pc_nxt)
   );

   always_comb begin
      state_nxt = state;
      if (exc_valid) begin
         // A redirect with a request in flight must still swallow its data.
         unique case (state)
            S_REQ:   state_nxt = req_acc ? S_DROP : S_REQ;
            S_WAIT:  state_nxt = inst_data_ok ? S_REQ : S_DROP;
            S_HOLD:  state_nxt = S_REQ;
            S_DROP:  state_nxt = inst_data_ok ? S_REQ : S_DROP;
            default: state_nxt = S_REQ;
         endcase
      end else begin
         unique case (state)
            S_REQ: begin
               if (misaligned)
                  state_nxt = S_HOLD;
               else if (req_acc)
                  state_nxt = S_WAIT;
            end
            S_WAIT:  if (inst_data_ok) state_nxt = S_HOLD;
            S_HOLD:  if (ID_allowin) state_nxt = S_REQ;
            S_DROP:  if (inst_data_ok) state_nxt = S_REQ;
            default: state_nxt = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state   <= S_REQ;
         pc      <= RESET_PC;
         br_pend <= 1'b0;
         br_tgt  <= '0;
         adel_r  <= 1'b0;
         inst_r  <= '0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;

         if (exc_valid) begin
            br_pend <= 1'b0;
         end else if (jbr_taken && !handoff) begin
            br_pend <= 1'b1;
            br_tgt  <= jbr_target;
         end else if (handoff) begin
            br_pend <= 1'b0;
         end

         if (!exc_valid) begin
            if (state == S_REQ && misaligned) begin
               adel_r <= 1'b1;
               inst_r <= '0;
            end else if (state == S_WAIT && inst_data_ok) begin
               adel_r <= 1'b0;
               inst_r <= inst_rdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: sram-like memory model, fetch-address and
// IF->ID scoreboards, and per-scenario hand-placed stimulus.
module tb_if_fetch;
   import cpu_defs::*;

   logic        clk = 1'b0;
   logic        resetn, exc_valid, jbr_taken, ID_allowin;
   logic [31:0] exc_pc, jbr_target;
   logic        inst_req, IF_valid;
   logic [31:0] inst_addr, IF_pc;
   logic        inst_addr_ok = 1'b0;
   logic        inst_data_ok = 1'b0;
   logic [31:0] inst_rdata   = 32'h0;
   logic [IF_ID_BUS_W-1:0] IF_ID_bus;

   int n_checks = 0;
   int n_errors = 0;

   int          lat    = 1;
   int          budget = 0;
   logic        pend   = 1'b0;
   int          cnt    = 0;
   logic [31:0] paddr  = 32'h0;

   logic [31:0] exp_req_q[$];
   logic [64:0] exp_bus_q[$];

   always #5 clk = ~clk;

   if_fetch dut (
      .clk          (clk),
      .resetn       (resetn),
      .exc_valid    (exc_valid),
      .exc_pc       (exc_pc),
      .jbr_taken    (jbr_taken),
      .jbr_target   (jbr_target),
      .ID_allowin   (ID_allowin),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_rdata   (inst_rdata),
      .inst_data_ok (inst_data_ok),
      .IF_valid     (IF_valid),
      .IF_ID_bus    (IF_ID_bus),
      .IF_pc        (IF_pc)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory: grants while it has budget, returns data lat cycles after grant.
   always @(negedge clk) begin
      #1;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      if (!resetn) begin
         pend = 1'b0;
      end else if (pend) begin
         check("no_req_outstanding", 65'(inst_req), 65'd0);
         if (cnt == 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_word(paddr);
            pend         = 1'b0;
         end else begin
            cnt--;
         end
      end else if (inst_req && budget > 0) begin
         inst_addr_ok = 1'b1;
         pend         = 1'b1;
         paddr        = inst_addr;
         cnt          = lat - 1;
         budget--;
         check("req_expected", 65'(exp_req_q.size() != 0), 65'd1);
         if (exp_req_q.size() != 0)
            check("req_addr", 65'(inst_addr), 65'(exp_req_q.pop_front()));
      end
   end

   always @(negedge clk) begin
      #2;
      if (resetn && IF_valid && ID_allowin) begin
         check("bus_expected", 65'(exp_bus_q.size() != 0), 65'd1);
         if (exp_bus_q.size() != 0)
            check("bus", IF_ID_bus, exp_bus_q.pop_front());
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic expect_fetch(input logic [31:0] a, input logic handed);
      exp_req_q.push_back(a);
      if (handed)
         exp_bus_q.push_back({1'b0, a, mem_word(a)});
   endtask

   task automatic do_reset(input int l, input int b);
      resetn     = 1'b0;
      exc_valid  = 1'b0;
      jbr_taken  = 1'b0;
      ID_allowin = 1'b1;
      tick();
      tick();
      check("rst_req", 65'(inst_req), 65'd0);
      check("rst_valid", 65'(IF_valid), 65'd0);
      check("rst_pc", 65'(IF_pc), 65'(RESET_PC));
      lat    = l;
      budget = b;
      resetn = 1'b1;
   endtask

   task automatic wait_drain();
      int i;
      i = 0;
      while ((exp_req_q.size() != 0 || exp_bus_q.size() != 0) && i < 200) begin
         tick();
         i++;
      end
      tick();
      tick();
      check("drain_req", 65'(exp_req_q.size()), 65'd0);
      check("drain_bus", 65'(exp_bus_q.size()), 65'd0);
      exp_req_q.delete();
      exp_bus_q.delete();
   endtask

   // Returns at the first negedge where the fetch of a is outstanding.
   task automatic wait_busy(input logic [31:0] a);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         tick();
         if (IF_pc == a && !IF_valid && !inst_req && pend)
            found = 1'b1;
      end
      check("wait_busy", 65'(found), 65'd1);
   endtask

   task automatic wait_hold(input logic [31:0] a);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         tick();
         if (IF_valid && IF_pc == a)
            found = 1'b1;
      end
      check("wait_hold", 65'(found), 65'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn     = 1'b0;
      exc_valid  = 1'b0;
      exc_pc     = 32'h0;
      jbr_taken  = 1'b0;
      jbr_target = 32'h0;
      ID_allowin = 1'b1;

      // Sequential fetch from the reset vector.
      expect_fetch(32'hBFC0_0000, 1'b1);
      expect_fetch(32'hBFC0_0004, 1'b1);
      expect_fetch(32'hBFC0_0008, 1'b1);
      do_reset(1, 3);
      wait_drain();
      check("seq_pc_after", 65'(IF_pc), 65'(32'hBFC0_000C));
      check("seq_valid_after", 65'(IF_valid), 65'd0);

      // Taken branch while the delay slot is being fetched.
      expect_fetch(32'hBFC0_0000, 1'b1);
      expect_fetch(32'hBFC0_0004, 1'b1);
      expect_fetch(32'hBFC0_0100, 1'b1);
      do_reset(1, 3);
      wait_busy(32'hBFC0_0004);
      jbr_taken  = 1'b1;
      jbr_target = 32'hBFC0_0100;
      tick();
      jbr_taken  = 1'b0;
      wait_drain();

      // Redirect in S_WAIT with late data: stale word must be dropped.
      expect_fetch(32'hBFC0_0000, 1'b0);
      expect_fetch(EXC_ENTER_ADDR, 1'b1);
      do_reset(4, 2);
      wait_busy(32'hBFC0_0000);
      exc_valid = 1'b1;
      exc_pc    = EXC_ENTER_ADDR;
      tick();
      exc_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("drop_req", 65'(inst_req), 65'd0);
         check("drop_valid", 65'(IF_valid), 65'd0);
         check("drop_pc", 65'(IF_pc), 65'(EXC_ENTER_ADDR));
         tick();
      end
      check("refetch_req", 65'(inst_req), 65'd1);
      check("refetch_addr", 65'(inst_addr), 65'(EXC_ENTER_ADDR));
      wait_drain();

      // Misaligned branch target raises AdEL without a fetch.
      expect_fetch(32'hBFC0_0000, 1'b1);
      do_reset(1, 1);
      wait_busy(32'hBFC0_0000);
      jbr_taken  = 1'b1;
      jbr_target = 32'hBFC0_0102;
      tick();
      jbr_taken  = 1'b0;
      wait_hold(32'hBFC0_0102);
      ID_allowin = 1'b0;
      check("adel_bus", IF_ID_bus, {1'b1, 32'hBFC0_0102, 32'h0});
      check("adel_req", 65'(inst_req), 65'd0);
      tick();
      check("adel_bus_held", IF_ID_bus, {1'b1, 32'hBFC0_0102, 32'h0});
      wait_drain();

      // ID stall for 5 cycles in S_HOLD.
      expect_fetch(32'hBFC0_0000, 1'b1);
      expect_fetch(32'hBFC0_0004, 1'b1);
      do_reset(1, 2);
      wait_hold(32'hBFC0_0000);
      ID_allowin = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_bus", IF_ID_bus, {1'b0, 32'hBFC0_0000, mem_word(32'hBFC0_0000)});
         check("stall_req", 65'(inst_req), 65'd0);
         tick();
      end
      ID_allowin = 1'b1;
      wait_drain();

      // Redirect and branch together: the redirect wins, the branch is lost.
      expect_fetch(32'hBFC0_0000, 1'b0);
      expect_fetch(EXC_ENTER_ADDR, 1'b1);
      expect_fetch(EXC_ENTER_ADDR + 32'd4, 1'b1);
      do_reset(1, 3);
      wait_busy(32'hBFC0_0000);
      exc_valid  = 1'b1;
      exc_pc     = EXC_ENTER_ADDR;
      jbr_taken  = 1'b1;
      jbr_target = 32'hBFC0_0200;
      tick();
      exc_valid  = 1'b0;
      jbr_taken  = 1'b0;
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
